// File: rtl/alu_micro.sv
// rtl/alu_micro.sv - 8-bit registered ALU, one-cycle latency, result R0 and flags Ban {N,C,Z}
// Optional build macro ALU_SAT_EN: saturating ADD/SUB instead of wrap-around.
module alu_micro #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] Rx,
    input  logic [WIDTH-1:0] Ry,
    input  logic [2:0]       Sel_op,
    output logic [WIDTH-1:0] R0,
    output logic [2:0]       Ban
);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_t;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res_next;
    logic             carry_next;

    // The extra top bit is the carry-out for ADD and the borrow for SUB.
    assign sum  = {1'b0, Rx} + {1'b0, Ry};
    assign diff = {1'b0, Rx} - {1'b0, Ry};

    always_comb begin
        res_next   = '0;
        carry_next = 1'b0;
        case (op_t'(Sel_op))
            OP_ADD: begin
                carry_next = sum[WIDTH];
`ifdef ALU_SAT_EN
                res_next   = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                res_next   = sum[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                carry_next = diff[WIDTH];
`ifdef ALU_SAT_EN
                res_next   = diff[WIDTH] ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
`else
                res_next   = diff[WIDTH-1:0];
`endif
            end
            OP_AND: res_next = Rx & Ry;
            OP_OR:  res_next = Rx | Ry;
            OP_XOR: res_next = Rx ^ Ry;
            OP_NOT: res_next = ~Rx;
            OP_SHL: begin
                res_next   = {Rx[WIDTH-2:0], 1'b0};
                carry_next = Rx[WIDTH-1];
            end
            OP_SHR: begin
                res_next   = {1'b0, Rx[WIDTH-1:1]};
                carry_next = Rx[0];
            end
            default: begin
                res_next   = '0;
                carry_next = 1'b0;
            end
        endcase
    end

    // Flags always follow the value actually written to R0 (clamped value in the saturating build).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            R0  <= '0;
            Ban <= 3'b000;
        end else if (en) begin
            R0  <= res_next;
            Ban <= {res_next[WIDTH-1], carry_next, (res_next == '0)};
        end
    end

endmodule

// File: tb/tb_alu_micro.sv
// tb/tb_alu_micro.sv - scoreboard bench for alu_micro with directed and random stimulus
module tb_alu_micro;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] Rx;
    logic [7:0] Ry;
    logic [2:0] Sel_op;
    logic [7:0] R0;
    logic [2:0] Ban;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] r;
        logic [2:0] b;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] model_r;
    logic [2:0] model_b;

    alu_micro #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .Rx     (Rx),
        .Ry     (Ry),
        .Sel_op (Sel_op),
        .R0     (R0),
        .Ban    (Ban)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer arithmetic straight from the opcode table.
    task automatic ref_model(input int op, input int a, input int b,
                             output logic [7:0] r, output logic [2:0] fl);
        int v;
        int c;
        v = 0;
        c = 0;
        case (op)
            0: begin v = a + b; c = (v > 255) ? 1 : 0;
`ifdef ALU_SAT_EN
                 if (c == 1) v = 255;
`endif
                 v = v % 256; end
            1: begin c = (a < b) ? 1 : 0; v = (a - b + 256) % 256;
`ifdef ALU_SAT_EN
                 if (c == 1) v = 0;
`endif
               end
            2: v = a & b;
            3: v = a | b;
            4: v = a ^ b;
            5: v = 255 - a;
            6: begin v = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
            default: begin v = a / 2; c = a % 2; end
        endcase
        r  = 8'(v);
        fl = {(v >= 128) ? 1'b1 : 1'b0, c[0], (v == 0) ? 1'b1 : 1'b0};
    endtask

    // Drive one cycle at the falling edge and queue what R0/Ban must show after the next rising edge.
    task automatic drive(input string name, input bit e, input int op, input int a, input int b);
        logic [7:0] r;
        logic [2:0] fl;
        exp_t       x;
        @(negedge clk);
        en     = e;
        Sel_op = 3'(op);
        Rx     = 8'(a);
        Ry     = 8'(b);
        if (!rst_n) begin
            model_r = 8'h00;
            model_b = 3'b000;
        end else if (e) begin
            ref_model(op, a, b, r, fl);
            model_r = r;
            model_b = fl;
        end
        x.r    = model_r;
        x.b    = model_b;
        x.name = name;
        exp_q.push_back(x);
    endtask

    // Directed check with the expected value written out by hand.
    task automatic drive_const(input string name, input int op, input int a, input int b,
                               input int er, input int eb);
        exp_t x;
        @(negedge clk);
        en     = 1'b1;
        Sel_op = 3'(op);
        Rx     = 8'(a);
        Ry     = 8'(b);
        model_r = 8'(er);
        model_b = 3'(eb);
        x.r    = model_r;
        x.b    = model_b;
        x.name = name;
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks++;
                if (R0 !== x.r || Ban !== x.b) begin
                    errors++;
                    $display("FAIL %s: got R0=%0d Ban=%b, expected R0=%0d Ban=%b",
                             x.name, R0, Ban, x.r, x.b);
                end
            end
        end
    end

    initial begin : stimulus
        int waited;
        rst_n = 1'b0; en = 1'b0; Rx = 8'h00; Ry = 8'h00; Sel_op = 3'd0;
        model_r = 8'h00; model_b = 3'b000;
        #2;
        checks++;
        if (R0 !== 8'h00 || Ban !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: got R0=%0d Ban=%b, expected R0=0 Ban=000", R0, Ban);
        end
        drive("in_reset_en1", 1'b1, 0, 5, 6);
        @(negedge clk);
        rst_n = 1'b1;

        drive_const("add_76_44", 0, 76, 44, 120, 3'b000);
        drive_const("sub_76_76", 1, 76, 76, 0, 3'b001);
`ifdef ALU_SAT_EN
        drive_const("sub_76_80", 1, 76, 80, 0, 3'b011);
        drive_const("add_200_100", 0, 200, 100, 255, 3'b110);
        drive_const("add_255_1", 0, 255, 1, 255, 3'b110);
        drive_const("sub_0_1", 1, 0, 1, 0, 3'b011);
`else
        drive_const("sub_76_80", 1, 76, 80, 252, 3'b110);
        drive_const("add_200_100", 0, 200, 100, 44, 3'b010);
        drive_const("add_255_1", 0, 255, 1, 0, 3'b011);
        drive_const("sub_0_1", 1, 0, 1, 255, 3'b110);
`endif
        drive_const("and_76_44", 2, 76, 44, 12, 3'b000);
        drive_const("or_76_44", 3, 76, 44, 108, 3'b000);
        drive_const("xor_76_44", 4, 76, 44, 96, 3'b000);
        drive_const("not_76", 5, 76, 44, 179, 3'b100);
        drive_const("shl_76", 6, 76, 0, 152, 3'b100);
        drive_const("shr_76", 7, 76, 0, 38, 3'b000);
        drive_const("shl_129", 6, 129, 0, 2, 3'b010);
        drive_const("shr_129", 7, 129, 0, 64, 3'b010);

        drive_const("pre_hold", 0, 76, 44, 120, 3'b000);
        for (int i = 0; i < 3; i++)
            drive("hold", 1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)));
        drive_const("after_hold", 1, 76, 80,
`ifdef ALU_SAT_EN
                    0, 3'b011);
`else
                    252, 3'b110);
`endif

        // Asynchronous reset in the middle of a cycle with R0 nonzero.
        drive_const("pre_async", 5, 0, 0, 255, 3'b100);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (R0 !== 8'h00 || Ban !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: got R0=%0d Ban=%b, expected R0=0 Ban=000", R0, Ban);
        end
        drive("reset_hold", 1'b1, 5, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive("first_after_reset", 1'b1, 0, 3, 4);

        for (int i = 0; i < 300; i++)
            drive("random", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected results left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
